// File: rtl/fp_norm_pkg.sv
// Shared widths, constants and result flags for the normalizer pipeline.
package fp_norm_pkg;
    localparam int EXP_W   = 8;
    localparam int MANT_W  = 32;
    localparam int SIG_W   = 24;
    localparam int LZ_W    = 5;
    localparam int GRD_W   = MANT_W - SIG_W;
    localparam int BIAS    = 127;
    localparam int EXP_MAX = 255;

    typedef struct packed {
        logic zero;
        logic uflow;
        logic oflow;
    } flags_t;
endpackage

// File: rtl/fp_norm_pipe_lead_one.sv
// One-hot marker of the most significant set bit; all zero for a zero input.
module lead_one_line
    import fp_norm_pkg::*;
(
    input  logic [MANT_W-1:0] mant_i,
    output logic [MANT_W-1:0] line_o
);
    logic seen;

    always_comb begin
        line_o = '0;
        seen   = 1'b0;
        for (int i = MANT_W - 1; i >= 0; i--) begin
            if (mant_i[i] && !seen) line_o[i] = 1'b1;
            seen = seen | mant_i[i];
        end
    end
endmodule

// File: rtl/fp_norm_pipe.sv
// Two-stage normalizer: S1 counts leading zeros, S2 shifts, adjusts the
// exponent and rounds to nearest-even, with valid/ready backpressure.
module fp_norm_pipe
    import fp_norm_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sign,
    input  logic [EXP_W-1:0]  in_exp,
    input  logic [MANT_W-1:0] in_mant,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_sign,
    output logic [EXP_W-1:0]  out_exp,
    output logic [SIG_W-1:0]  out_sig,
    output logic              out_zero,
    output logic              out_uflow,
    output logic              out_oflow
);
    logic              v1_q, v2_q;
    logic              rdy1, rdy2;
    logic              sign1_q, zin1_q;
    logic [EXP_W-1:0]  exp1_q;
    logic [MANT_W-1:0] mant1_q;
    logic [LZ_W-1:0]   lz1_q;
    logic [MANT_W-1:0] line;
    logic [LZ_W-1:0]   lz_d;
    logic              zin_d;

    logic              sign2_q, sign2_d;
    logic [EXP_W-1:0]  exp2_q, exp2_d;
    logic [SIG_W-1:0]  sig2_q, sig2_d;
    flags_t            flags2_q, flags2_d;

    logic [MANT_W-1:0]       m2;
    logic signed [EXP_W+1:0] exp_n, exp_f;
    logic                    rnd_up, carry;
    logic [SIG_W:0]          sum;

    assign rdy2     = ~v2_q | out_ready;
    assign rdy1     = ~v1_q | rdy2;
    assign in_ready = rdy1;

    lead_one_line u_lead (
        .mant_i (in_mant),
        .line_o (line)
    );

    always_comb begin
        lz_d = '0;
        for (int i = 0; i < MANT_W; i++) begin
            if (line[i]) lz_d = lz_d | LZ_W'(MANT_W - 1 - i);
        end
        zin_d = ~|in_mant;
    end

    // Exponent math is two bits wider so underflow shows as <= 0 and a
    // rounding carry out of 255 is still visible.
    always_comb begin
        m2     = mant1_q << lz1_q;
        exp_n  = $signed({2'b00, exp1_q}) - $signed({{(EXP_W + 2 - LZ_W){1'b0}}, lz1_q});
        rnd_up = m2[GRD_W-1] & ((|m2[GRD_W-2:0]) | m2[GRD_W]);
        sum    = {1'b0, m2[MANT_W-1:GRD_W]} + {{SIG_W{1'b0}}, rnd_up};
        carry  = sum[SIG_W];
        exp_f  = exp_n + {{(EXP_W + 1){1'b0}}, carry};

        sign2_d  = sign1_q;
        exp2_d   = '0;
        sig2_d   = '0;
        flags2_d = '0;
        if (zin1_q) begin
            flags2_d.zero = 1'b1;
        end else if (exp_n[EXP_W+1] || exp_n == '0) begin
            flags2_d.uflow = 1'b1;
            flags2_d.zero  = 1'b1;
        end else if (exp_f[EXP_W:0] >= (EXP_W + 1)'(EXP_MAX)) begin
            flags2_d.oflow = 1'b1;
            exp2_d         = EXP_W'(EXP_MAX);
        end else begin
            exp2_d = exp_f[EXP_W-1:0];
            sig2_d = carry ? {1'b1, {(SIG_W - 1){1'b0}}} : sum[SIG_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q    <= 1'b0;
            sign1_q <= 1'b0;
            exp1_q  <= '0;
            mant1_q <= '0;
            lz1_q   <= '0;
            zin1_q  <= 1'b0;
        end else if (rdy1) begin
            v1_q <= in_valid;
            if (in_valid) begin
                sign1_q <= in_sign;
                exp1_q  <= in_exp;
                mant1_q <= in_mant;
                lz1_q   <= lz_d;
                zin1_q  <= zin_d;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2_q     <= 1'b0;
            sign2_q  <= 1'b0;
            exp2_q   <= '0;
            sig2_q   <= '0;
            flags2_q <= '0;
        end else if (rdy2) begin
            v2_q <= v1_q;
            if (v1_q) begin
                sign2_q  <= sign2_d;
                exp2_q   <= exp2_d;
                sig2_q   <= sig2_d;
                flags2_q <= flags2_d;
            end
        end
    end

    assign out_valid = v2_q;
    assign out_sign  = sign2_q;
    assign out_exp   = exp2_q;
    assign out_sig   = sig2_q;
    assign out_zero  = flags2_q.zero;
    assign out_uflow = flags2_q.uflow;
    assign out_oflow = flags2_q.oflow;
endmodule

// File: tb/tb_fp_norm_pipe.sv
// Directed bench for fp_norm_pipe: single beats with hand-computed results,
// a stalled back-to-back stream and a mid-stream reset.
module tb_fp_norm_pipe;
    logic        clk, rst;
    logic        in_valid, in_ready, in_sign;
    logic [7:0]  in_exp;
    logic [31:0] in_mant;
    logic        out_valid, out_ready, out_sign;
    logic [7:0]  out_exp;
    logic [23:0] out_sig;
    logic        out_zero, out_uflow, out_oflow;

    int checks = 0;
    int errors = 0;

    fp_norm_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sign   (in_sign),
        .in_exp    (in_exp),
        .in_mant   (in_mant),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sign  (out_sign),
        .out_exp   (out_exp),
        .out_sig   (out_sig),
        .out_zero  (out_zero),
        .out_uflow (out_uflow),
        .out_oflow (out_oflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one beat into an idle pipe and captures its result; lat counts
    // cycles from the presenting cycle to the cycle out_valid is seen.
    task automatic run_beat(input logic s, input logic [7:0] e, input logic [31:0] m,
                            output logic os, output logic [7:0] oe, output logic [23:0] osig,
                            output logic [2:0] ofl, output int lat);
        in_valid  = 1'b1;
        in_sign   = s;
        in_exp    = e;
        in_mant   = m;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) begin
            checks++; errors++;
            $display("FAIL timeout mant=%h exp=%0d: out_valid never rose", m, e);
        end
        os   = out_sign;
        oe   = out_exp;
        osig = out_sig;
        ofl  = {out_zero, out_uflow, out_oflow};
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b0; in_sign = 1'b0; in_exp = '0; in_mant = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_exp !== 8'd0 || out_sig !== 24'd0 || out_sign !== 1'b0 ||
            {out_zero, out_uflow, out_oflow} !== 3'b000) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b e=%0d sig=%h s=%b fl=%b, want all zero",
                     out_valid, out_exp, out_sig, out_sign, {out_zero, out_uflow, out_oflow});
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_basic;
        logic s; logic [7:0] e; logic [23:0] g; logic [2:0] f; int lat;
        run_beat(1'b1, 8'd130, 32'h80000000, s, e, g, f, lat);
        checks++;
        if (lat !== 2) begin errors++; $display("FAIL latency: got %0d want 2", lat); end
        checks++;
        if (e !== 8'd130 || g !== 24'h800000 || f !== 3'b000 || s !== 1'b1) begin
            errors++;
            $display("FAIL basic: got e=%0d sig=%h fl=%b s=%b want 130 800000 000 1", e, g, f, s);
        end
    endtask

    task automatic test_lz;
        logic s; logic [7:0] e; logic [23:0] g; logic [2:0] f; int lat;
        run_beat(1'b0, 8'd140, 32'h00000001, s, e, g, f, lat);
        checks++;
        if (e !== 8'd109 || g !== 24'h800000 || f !== 3'b000) begin
            errors++; $display("FAIL lz31: got e=%0d sig=%h fl=%b want 109 800000 000", e, g, f);
        end
        run_beat(1'b0, 8'd100, 32'h00000180, s, e, g, f, lat);
        checks++;
        if (e !== 8'd77 || g !== 24'hC00000 || f !== 3'b000) begin
            errors++; $display("FAIL lz23: got e=%0d sig=%h fl=%b want 77 c00000 000", e, g, f);
        end
    endtask

    task automatic test_round;
        logic s; logic [7:0] e; logic [23:0] g; logic [2:0] f; int lat;
        run_beat(1'b0, 8'd200, 32'hFFFFFF80, s, e, g, f, lat);
        checks++;
        if (e !== 8'd201 || g !== 24'h800000 || f !== 3'b000) begin
            errors++; $display("FAIL round_carry: got e=%0d sig=%h fl=%b want 201 800000 000", e, g, f);
        end
        run_beat(1'b0, 8'd100, 32'h00000181, s, e, g, f, lat);
        checks++;
        if (e !== 8'd77 || g !== 24'hC08000) begin
            errors++; $display("FAIL round_exact: got e=%0d sig=%h want 77 c08000", e, g);
        end
        run_beat(1'b0, 8'd130, 32'h80000080, s, e, g, f, lat);
        checks++;
        if (e !== 8'd130 || g !== 24'h800000) begin
            errors++; $display("FAIL round_tie_even: got e=%0d sig=%h want 130 800000", e, g);
        end
        run_beat(1'b0, 8'd130, 32'h80000180, s, e, g, f, lat);
        checks++;
        if (e !== 8'd130 || g !== 24'h800002) begin
            errors++; $display("FAIL round_tie_odd: got e=%0d sig=%h want 130 800002", e, g);
        end
    endtask

    task automatic test_zero_uflow;
        logic s; logic [7:0] e; logic [23:0] g; logic [2:0] f; int lat;
        run_beat(1'b1, 8'd77, 32'h00000000, s, e, g, f, lat);
        checks++;
        if (e !== 8'd0 || g !== 24'd0 || f !== 3'b100 || s !== 1'b1) begin
            errors++; $display("FAIL zero: got e=%0d sig=%h fl=%b s=%b want 0 0 100 1", e, g, f, s);
        end
        run_beat(1'b0, 8'd10, 32'h00010000, s, e, g, f, lat);
        checks++;
        if (e !== 8'd0 || g !== 24'd0 || f !== 3'b110) begin
            errors++; $display("FAIL uflow: got e=%0d sig=%h fl=%b want 0 0 110", e, g, f);
        end
        run_beat(1'b1, 8'd15, 32'h00010000, s, e, g, f, lat);
        checks++;
        if (e !== 8'd0 || g !== 24'd0 || f !== 3'b110 || s !== 1'b1) begin
            errors++; $display("FAIL uflow_edge: got e=%0d sig=%h fl=%b s=%b want 0 0 110 1", e, g, f, s);
        end
        run_beat(1'b0, 8'd16, 32'h00010000, s, e, g, f, lat);
        checks++;
        if (e !== 8'd1 || g !== 24'h800000 || f !== 3'b000) begin
            errors++; $display("FAIL min_normal: got e=%0d sig=%h fl=%b want 1 800000 000", e, g, f);
        end
    endtask

    task automatic test_oflow;
        logic s; logic [7:0] e; logic [23:0] g; logic [2:0] f; int lat;
        run_beat(1'b1, 8'd254, 32'hFFFFFF80, s, e, g, f, lat);
        checks++;
        if (e !== 8'd255 || g !== 24'd0 || f !== 3'b001 || s !== 1'b1) begin
            errors++; $display("FAIL oflow: got e=%0d sig=%h fl=%b s=%b want 255 0 001 1", e, g, f, s);
        end
        run_beat(1'b0, 8'd254, 32'h80000000, s, e, g, f, lat);
        checks++;
        if (e !== 8'd254 || g !== 24'h800000 || f !== 3'b000) begin
            errors++; $display("FAIL max_normal: got e=%0d sig=%h fl=%b want 254 800000 000", e, g, f);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] bm[6];
        logic [7:0]  be[6], xe[6];
        logic [23:0] xs[6];
        logic        hv, hs, stalled;
        logic [7:0]  he;
        logic [23:0] hg;
        int sent, got, idle_hits;
        bm = '{32'h80000000, 32'h00000001, 32'h00000180, 32'hFFFFFF80, 32'h00000181, 32'h80000080};
        be = '{8'd130, 8'd140, 8'd100, 8'd200, 8'd100, 8'd130};
        xe = '{8'd130, 8'd109, 8'd77, 8'd201, 8'd77, 8'd130};
        xs = '{24'h800000, 24'h800000, 24'hC00000, 24'h800000, 24'hC08000, 24'h800000};
        sent = 0; got = 0; hv = 1'b0; stalled = 1'b0;
        hs = 1'b0; he = '0; hg = '0;
        for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
            in_valid = (sent < 6);
            if (sent < 6) begin
                in_sign = sent[0];
                in_exp  = be[sent];
                in_mant = bm[sent];
            end
            out_ready = !(cyc >= 3 && cyc <= 6);
            #1;
            if (!in_ready) stalled = 1'b1;
            if (hv) begin
                checks++;
                if (out_valid !== 1'b1 || out_exp !== he || out_sig !== hg || out_sign !== hs) begin
                    errors++;
                    $display("FAIL hold_stable cyc%0d: got v=%b e=%0d sig=%h s=%b want 1 %0d %h %b",
                             cyc, out_valid, out_exp, out_sig, out_sign, he, hg, hs);
                end
            end
            hv = out_valid && !out_ready;
            he = out_exp; hg = out_sig; hs = out_sign;
            if (out_valid && out_ready) begin
                checks++;
                if (out_exp !== xe[got] || out_sig !== xs[got] || out_sign !== got[0] ||
                    {out_zero, out_uflow, out_oflow} !== 3'b000) begin
                    errors++;
                    $display("FAIL stream[%0d]: got e=%0d sig=%h s=%b want %0d %h %b",
                             got, out_exp, out_sig, out_sign, xe[got], xs[got], got[0]);
                end
                got++;
            end
            if (in_valid && in_ready) sent++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        checks++;
        if (got !== 6) begin errors++; $display("FAIL stream_count: got %0d want 6", got); end
        checks++;
        if (stalled !== 1'b1) begin errors++; $display("FAIL in_ready_drop: got never-low want low"); end
        idle_hits = 0;
        repeat (4) begin
            #1;
            if (out_valid) idle_hits++;
            @(posedge clk); #1;
        end
        checks++;
        if (idle_hits !== 0) begin errors++; $display("FAIL no_dup: got %0d extra beats want 0", idle_hits); end
    endtask

    task automatic test_reset_mid;
        int hits;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_sign   = 1'b1;
        in_exp    = 8'd130;
        in_mant   = 32'h80000000;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL pre_reset_valid: got %b want 1", out_valid); end
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_exp !== 8'd0 || out_sign !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: got v=%b e=%0d s=%b want 0 0 0", out_valid, out_exp, out_sign);
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        hits = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (out_valid) hits++;
        end
        checks++;
        if (hits !== 0) begin errors++; $display("FAIL reset_discard: got %0d beats want 0", hits); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_lz();
        test_round();
        test_zero_uflow();
        test_oflow();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
